// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks: scan states,
// the active-low hex glyph table and the all-segments-off pattern.
package seg7_pkg;

  typedef enum logic [0:0] {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for nibble values 0..F
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Host-side load bus and board-side pin group of the display controller.
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_en;
  logic                    load;
  logic                    pending;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output digits, blank, dp_in, lz_en, load,
    input  pending, frame_done, an, seg, dp
  );

  modport slave (
    input  digits, blank, dp_in, lz_en, load,
    output pending, frame_done, an, seg, dp
  );
endinterface

// File: rtl/seg7_hex_encode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_encode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multiplexed seven-segment scanner with prescaler, dead time between digits,
// leading-zero suppression and a frame-aligned shadow load path.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIVIDE_BY  = 17,
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  seg7_display_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GC_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GC_W-1:0]  GC_INIT  = GC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [0:0] ST_SHOW = SHOW;
  localparam logic [0:0] ST_GAP  = GAP;

  logic [DIVIDE_BY-1:0]    r_presc;
  logic [0:0]              r_state;
  logic [GC_W-1:0]         r_gap_cnt;
  logic [IDX_W-1:0]        r_idx;

  logic [4*NUM_DIGITS-1:0] r_stg_digits, r_act_digits;
  logic [NUM_DIGITS-1:0]   r_stg_blank,  r_act_blank;
  logic [NUM_DIGITS-1:0]   r_stg_dp,     r_act_dp;
  logic                    r_pending;
  logic                    r_frame_done;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_tick;
  logic                    w_advance;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_dark;
  logic                    w_above_clear;
  logic [3:0]              w_nib;
  logic [3:0]              w_cur_nib;
  logic [6:0]              w_glyph;

  assign w_tick    = &r_presc;
  assign w_advance = (r_state == ST_SHOW) ? (w_tick && (GAP_CYCLES == 0))
                                          : (r_gap_cnt == '0);
  assign w_wrap    = w_advance && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc   <= '0;
      r_state   <= ST_SHOW;
      r_gap_cnt <= '0;
      r_idx     <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (r_state == ST_SHOW) begin
        if (w_tick && (GAP_CYCLES > 0)) begin
          r_state   <= ST_GAP;
          r_gap_cnt <= GC_INIT;
        end
      end else if (r_gap_cnt == '0) begin
        r_state <= ST_SHOW;
      end else begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
      if (w_advance)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Shadow path: staging always takes the newest load; active only changes at wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stg_digits <= '0;
      r_stg_blank  <= '1;
      r_stg_dp     <= '0;
      r_act_digits <= '0;
      r_act_blank  <= '1;
      r_act_dp     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_wrap && r_pending) begin
        r_act_digits <= r_stg_digits;
        r_act_blank  <= r_stg_blank;
        r_act_dp     <= r_stg_dp;
      end
      if (bus.load) begin
        r_stg_digits <= bus.digits;
        r_stg_blank  <= bus.blank;
        r_stg_dp     <= bus.dp_in;
        r_pending    <= 1'b1;
      end else if (w_wrap) begin
        r_pending    <= 1'b0;
      end
    end
  end

  // Scan from the most significant digit down, tracking whether everything above is empty
  always_comb begin
    w_dark        = '0;
    w_above_clear = 1'b1;
    w_nib         = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_nib     = r_act_digits[4*i +: 4];
      w_dark[i] = r_act_blank[i] ||
                  (bus.lz_en && (i > 0) && (w_nib == 4'h0) && w_above_clear);
      w_above_clear = w_above_clear && ((w_nib == 4'h0) || r_act_blank[i]);
    end
  end

  assign w_cur_nib = r_act_digits[4*int'(r_idx) +: 4];

  seg7_hex_encode u_hex (
    .i_nib (w_cur_nib),
    .o_seg (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else if (r_state == ST_SHOW) begin
      r_an  <= ~(NUM_DIGITS'(1) << r_idx);
      r_seg <= w_dark[r_idx] ? SEG_OFF : w_glyph;
      r_dp  <= ~r_act_dp[r_idx];
    end else begin
      r_an  <= '1;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed and randomized bench for seg7_display_ctrl against a cycle-level
// behavioural model of the scan, shadow load and digit-visibility rules.
module tb_seg7_display_ctrl;

  localparam int N = 4;
  localparam int D = 2;
  localparam int G = 1;
  localparam int PERIOD = 1 << D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  seg7_display_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg7_display_ctrl #(.NUM_DIGITS(N), .DIVIDE_BY(D), .GAP_CYCLES(G)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: time within prescaler period, gap cycles left (-1 = showing), digit index
  int         m_cnt, m_gap, m_idx;
  logic [15:0] m_sd, m_ad;
  logic [3:0]  m_sb, m_ab, m_sp, m_ap;
  logic        m_pend;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_pend, e_fd;

  logic [6:0]  col_seg [N];
  logic        col_dp  [N];

  function automatic int nib(logic [15:0] v, int i);
    return int'((v >> (4*i)) & 16'hF);
  endfunction

  function automatic logic is_dark(int i, logic lz);
    logic all_above;
    if (m_ab[i]) return 1'b1;
    if (!lz || i == 0 || nib(m_ad, i) != 0) return 1'b0;
    all_above = 1'b1;
    for (int j = i + 1; j < N; j++)
      if (nib(m_ad, j) != 0 && !m_ab[j]) all_above = 1'b0;
    return all_above;
  endfunction

  task automatic model_step();
    logic adv, wrap;
    if (!reset_n) begin
      m_cnt = 0; m_gap = -1; m_idx = 0;
      m_sd = '0; m_ad = '0; m_sb = '1; m_ab = '1; m_sp = '0; m_ap = '0;
      m_pend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_pend = 1'b0; e_fd = 1'b0;
      return;
    end
    if (m_gap < 0) begin
      e_an  = ~(4'b0001 << m_idx);
      e_seg = is_dark(m_idx, bus.lz_en) ? 7'h7F : hex_tab[nib(m_ad, m_idx)];
      e_dp  = ~m_ap[m_idx];
    end else begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end
    adv = 1'b0;
    if (m_gap < 0) begin
      if (m_cnt == PERIOD - 1) begin
        if (G > 0) m_gap = G - 1;
        else adv = 1'b1;
      end
    end else if (m_gap == 0) begin
      adv = 1'b1;
      m_gap = -1;
    end else begin
      m_gap--;
    end
    wrap = adv && (m_idx == N - 1);
    e_fd = wrap;
    if (wrap && m_pend) begin
      m_ad = m_sd; m_ab = m_sb; m_ap = m_sp;
    end
    if (bus.load) begin
      m_sd = bus.digits; m_sb = bus.blank; m_sp = bus.dp_in; m_pend = 1'b1;
    end else if (wrap) begin
      m_pend = 1'b0;
    end
    e_pend = m_pend;
    if (adv) m_idx = (m_idx + 1) % N;
    m_cnt = (m_cnt + 1) % PERIOD;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("an", 32'(bus.an), 32'(e_an));
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("dp", 32'(bus.dp), 32'(e_dp));
    chk("pending", 32'(bus.pending), 32'(e_pend));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  task automatic do_load(logic [15:0] d, logic [3:0] b, logic [3:0] p);
    bus.digits = d; bus.blank = b; bus.dp_in = p; bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic wait_fd();
    int k;
    for (k = 0; k < 40; k++) begin
      cyc();
      if (bus.frame_done === 1'b1) break;
    end
    chk("frame_done_timeout", 32'(k < 40), 32'd1);
  endtask

  // Starts right after a frame boundary; records the glyph seen under each anode
  task automatic collect_frame();
    for (int i = 0; i < N; i++) begin
      col_seg[i] = 7'bx; col_dp[i] = 1'bx;
    end
    for (int c = 0; c < N * PERIOD - 1; c++) begin
      cyc();
      for (int i = 0; i < N; i++)
        if (bus.an === ~(4'b0001 << i)) begin
          col_seg[i] = bus.seg; col_dp[i] = bus.dp;
        end
    end
  endtask

  task automatic expect_frame(string tag, logic [27:0] segs, logic [3:0] dps);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_seg"}, 32'(col_seg[i]), 32'((segs >> (7*i)) & 28'h7F));
      chk({tag, "_dp"}, 32'(col_dp[i]), 32'(dps[i]));
    end
  endtask

  initial begin
    logic seen_lit, seen_11;
    int k;
    bus.digits = '0; bus.blank = '0; bus.dp_in = '0; bus.lz_en = 1'b0; bus.load = 1'b0;

    // Reset hold
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("reset_an", 32'(bus.an), 32'hF);
    chk("reset_seg", 32'(bus.seg), 32'h7F);
    chk("reset_pending", 32'(bus.pending), 32'h0);
    reset_n = 1'b1;

    // 1: idle scan with everything blank
    seen_lit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (bus.seg !== 7'h7F) seen_lit = 1'b1;
    end
    chk("idle_dark", 32'(seen_lit), 32'h0);

    // 2: basic load and commit
    do_load(16'h12AF, 4'b0000, 4'b0100);
    chk("load_pending", 32'(bus.pending), 32'h1);
    wait_fd();
    chk("commit_pending", 32'(bus.pending), 32'h0);
    collect_frame();
    expect_frame("hex12AF", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);

    // 3: leading-zero suppression
    bus.lz_en = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_fd();
    collect_frame();
    expect_frame("lz0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_fd();
    collect_frame();
    expect_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
    bus.lz_en = 1'b0;

    // 4: latest load wins before the wrap
    wait_fd();
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (3) cyc();
    do_load(16'h2222, 4'b0000, 4'b0000);
    seen_11 = 1'b0;
    for (k = 0; k < 40; k++) begin
      cyc();
      if (bus.seg === 7'h79) seen_11 = 1'b1;
      if (bus.frame_done === 1'b1) break;
    end
    chk("wait4_timeout", 32'(k < 40), 32'd1);
    collect_frame();
    for (int i = 0; i < N; i++) if (col_seg[i] === 7'h79) seen_11 = 1'b1;
    chk("never_11", 32'(seen_11), 32'h0);
    expect_frame("hex2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // 5: load landing on the wrap cycle
    wait_fd();
    do_load(16'h8888, 4'b0000, 4'b0000);
    for (k = 0; k < 40; k++) begin
      if (m_gap == 0 && m_idx == N - 1) break;
      cyc();
    end
    chk("wrap_align_timeout", 32'(k < 40), 32'd1);
    do_load(16'h3333, 4'b0000, 4'b0000);
    chk("wrap_load_fd", 32'(bus.frame_done), 32'h1);
    chk("wrap_load_pending", 32'(bus.pending), 32'h1);
    collect_frame();
    expect_frame("old8888", {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111);
    chk("still_pending", 32'(bus.pending), 32'h1);
    wait_fd();
    chk("second_commit", 32'(bus.pending), 32'h0);
    collect_frame();
    expect_frame("new3333", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111);

    // 6: reset during GAP with a load pending
    do_load(16'h4567, 4'b0000, 4'b1111);
    for (k = 0; k < 40; k++) begin
      if (m_gap >= 0 && m_pend) break;
      cyc();
    end
    chk("gap_align_timeout", 32'(k < 40), 32'd1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("gap_rst_an", 32'(bus.an), 32'hF);
    chk("gap_rst_seg", 32'(bus.seg), 32'h7F);
    chk("gap_rst_pending", 32'(bus.pending), 32'h0);
    seen_lit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc();
      if (bus.seg !== 7'h7F) seen_lit = 1'b1;
    end
    chk("post_rst_dark", 32'(seen_lit), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.digits = 16'($urandom);
      bus.blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.dp_in  = 4'($urandom);
      bus.lz_en  = 1'($urandom);
      bus.load   = ($urandom_range(0, 9) == 0);
      reset_n    = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 1) == 0) bus.digits[15:8] = 8'h00;
      cyc();
    end
    bus.load = 1'b0;
    reset_n  = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
